// File: rtl/console_pkg.sv
// Shared types and constants for the console streamer.
//   CONSOLE_ADDR_DEF : default MMIO address of the console write port
//   mode_e           : PATTERN (arithmetic sequence) or STRING (NUL-terminated fetch)
//   state_e          : streamer FSM states
//   align8()         : clears address bits [2:0]
package console_pkg;

   localparam logic [63:0] CONSOLE_ADDR_DEF = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam int unsigned WORD_W           = 64;
   localparam int unsigned BYTE_W           = 8;
   localparam int unsigned IDX_W            = 3;

   typedef enum logic [0:0] {
      MODE_PATTERN = 1'b0,
      MODE_STRING  = 1'b1
   } mode_e;

   typedef enum logic [2:0] {
      START  = 3'd0,
      FETCH  = 3'd1,
      EMIT_P = 3'd2,
      EMIT_S = 3'd3,
      DONE   = 3'd4
   } state_e;

   function automatic logic [WORD_W-1:0] align8(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/console_word_buf.sv
// Word buffer for STRING mode: holds one fetched 64-bit word and walks it byte by byte.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_i, data_i    capture a fetched word and restart at byte 0
//   adv_i             step to the next byte
//   cur_byte_c_o      byte at the current index (little-endian: index 0 = bits [7:0])
//   is_nul_c_o        current byte is 8'h00
//   last_byte_c_o     current index is 7
module console_word_buf
   import console_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              adv_i,
   output logic [BYTE_W-1:0] cur_byte_c_o,
   output logic              is_nul_c_o,
   output logic              last_byte_c_o
);

   logic [WORD_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]  idx_q,  idx_d;

   // Load has priority over advance; a load always restarts at byte 0.
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (load_i) begin
         word_d = data_i;
         idx_d  = '0;
      end else if (adv_i) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   assign cur_byte_c_o  = word_q[{idx_q, 3'b000} +: BYTE_W];
   assign is_nul_c_o    = (cur_byte_c_o == '0);
   assign last_byte_c_o = (idx_q == {IDX_W{1'b1}});

endmodule

// File: rtl/console_streamer.sv
// Stand-in CPU driver that streams characters to the MMIO console, then raises done.
// PATTERN mode writes FIRST_CHAR, FIRST_CHAR+STEP, ... up to LAST_CHAR.
// STRING mode fetches a NUL-terminated string as 64-bit words and writes it byte by byte.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   done                   sticky completion flag
//   mem_ren, mem_raddr     read request and 8-byte aligned address (held until mem_rready)
//   mem_rready, mem_rdata  read completion and little-endian data word
//   mem_wen, mem_waddr     console write strobe and constant console address
//   mem_wdata              character, zero-extended
module console_streamer
   import console_pkg::*;
#(
   parameter int unsigned MODE         = 0,
   parameter logic [7:0]  FIRST_CHAR   = 8'h41,
   parameter logic [7:0]  LAST_CHAR    = 8'h5A,
   parameter logic [7:0]  STEP         = 8'd1,
   parameter logic [63:0] STR_ADDR     = 64'h1000,
   parameter int unsigned MAX_CHARS    = 256,
   parameter logic [63:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        done,
   output logic        mem_ren,
   output logic [63:0] mem_raddr,
   input  logic        mem_rready,
   input  logic [63:0] mem_rdata,
   output logic        mem_wen,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata
);

   localparam int unsigned  CNT_W     = $clog2(MAX_CHARS + 1);
   localparam mode_e        MODE_SEL  = (MODE == 1) ? MODE_STRING : MODE_PATTERN;
   localparam logic [63:0]  BASE_ADDR = align8(STR_ADDR);

   state_e              state_q, state_d;
   logic                done_q,  done_d;
   logic                ren_q,   ren_d;
   logic [63:0]         raddr_q, raddr_d;
   logic                wen_q,   wen_d;
   logic [BYTE_W-1:0]   wdata_q, wdata_d;
   logic [BYTE_W-1:0]   char_q,  char_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [BYTE_W:0]     pat_sum_c;
   logic [CNT_W-1:0]    count_inc_c;
   logic                buf_load_c;
   logic                buf_adv_c;
   logic [BYTE_W-1:0]   cur_byte_c;
   logic                is_nul_c;
   logic                last_byte_c;

   console_word_buf u_word_buf (
      .clk           (clk),
      .rst           (rst),
      .load_i        (buf_load_c),
      .data_i        (mem_rdata),
      .adv_i         (buf_adv_c),
      .cur_byte_c_o  (cur_byte_c),
      .is_nul_c_o    (is_nul_c),
      .last_byte_c_o (last_byte_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      done_d      = done_q;
      ren_d       = ren_q;
      raddr_d     = raddr_q;
      wen_d       = 1'b0;
      wdata_d     = wdata_q;
      char_d      = char_q;
      count_d     = count_q;
      buf_load_c  = 1'b0;
      buf_adv_c   = 1'b0;
      // 9-bit sum: an 8-bit carry-out ends the sequence instead of wrapping.
      pat_sum_c   = {1'b0, char_q} + {1'b0, STEP};
      count_inc_c = count_q + CNT_W'(1);

      case (state_q)
         START: begin
            if (MODE_SEL == MODE_STRING) begin
               ren_d   = 1'b1;
               raddr_d = BASE_ADDR;
               state_d = FETCH;
            end else if (FIRST_CHAR <= LAST_CHAR) begin
               wen_d   = 1'b1;
               wdata_d = FIRST_CHAR;
               char_d  = FIRST_CHAR;
               state_d = EMIT_P;
            end else begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         EMIT_P: begin
            if (pat_sum_c <= {1'b0, LAST_CHAR}) begin
               wen_d   = 1'b1;
               wdata_d = pat_sum_c[BYTE_W-1:0];
               char_d  = pat_sum_c[BYTE_W-1:0];
            end else begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         FETCH: begin
            if (mem_rready) begin
               buf_load_c = 1'b1;
               ren_d      = 1'b0;
               state_d    = EMIT_S;
            end
         end
         EMIT_S: begin
            if (is_nul_c) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               wen_d   = 1'b1;
               wdata_d = cur_byte_c;
               count_d = count_inc_c;
               if (count_inc_c == CNT_W'(MAX_CHARS)) begin
                  // Cap reached: done follows on the next edge from DONE.
                  state_d = DONE;
               end else if (last_byte_c) begin
                  // The eighth write and the next read request share a cycle.
                  ren_d   = 1'b1;
                  raddr_d = raddr_q + 64'd8;
                  state_d = FETCH;
               end else begin
                  buf_adv_c = 1'b1;
               end
            end
         end
         DONE: begin
            done_d = 1'b1;
            ren_d  = 1'b0;
         end
         default: state_d = START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= START;
         done_q  <= 1'b0;
         ren_q   <= 1'b0;
         raddr_q <= BASE_ADDR;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         char_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         ren_q   <= ren_d;
         raddr_q <= raddr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         char_q  <= char_d;
         count_q <= count_d;
      end
   end

   assign done      = done_q;
   assign mem_ren   = ren_q;
   assign mem_raddr = raddr_q;
   assign mem_wen   = wen_q;
   assign mem_waddr = CONSOLE_ADDR;
   assign mem_wdata = 64'(wdata_q);

endmodule
